// File: rtl/pic10_pkg.sv
// Shared types and constants for the PIC10 baseline control unit.
// No timing of its own; consumed by the decoder and the controller.
// No flow control: constants and types only.
package pic10_pkg;

    // FSM states; phase exposes the low two bits, so S_SLEEP reads as phase 0.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_SLEEP  = 3'd4
    } state_t;

    // ALU function codes. Byte-oriented file ops drive IR[9:6] straight through,
    // so codes 2..15 follow the opcode field. Codes 0/1 are free in that field
    // and carry MOVWF (pass W) and CLRW/CLRF (zero). BCF/BSF reuse AND/IOR; the
    // datapath puts the bit mask from IR[7:5] (inverted for BCF) on operand A.
    localparam logic [3:0] ALU_PASS_W = 4'd0;
    localparam logic [3:0] ALU_ZERO   = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;
    localparam logic [3:0] ALU_DEC    = 4'd3;
    localparam logic [3:0] ALU_IOR    = 4'd4;
    localparam logic [3:0] ALU_AND    = 4'd5;
    localparam logic [3:0] ALU_XOR    = 4'd6;
    localparam logic [3:0] ALU_ADD    = 4'd7;
    localparam logic [3:0] ALU_MOV    = 4'd8;
    localparam logic [3:0] ALU_COM    = 4'd9;
    localparam logic [3:0] ALU_INC    = 4'd10;
    localparam logic [3:0] ALU_DECSZ  = 4'd11;
    localparam logic [3:0] ALU_RR     = 4'd12;
    localparam logic [3:0] ALU_RL     = 4'd13;
    localparam logic [3:0] ALU_SWAP   = 4'd14;
    localparam logic [3:0] ALU_INCSZ  = 4'd15;

    // PC load source select.
    localparam logic [1:0] PC_SRC_GOTO  = 2'd0;
    localparam logic [1:0] PC_SRC_CALL  = 2'd1;
    localparam logic [1:0] PC_SRC_STACK = 2'd2;

    typedef enum logic [1:0] {FLOW_SEQ, FLOW_GOTO, FLOW_CALL, FLOW_RETLW} flow_t;
    typedef enum logic [1:0] {SKIP_NONE, SKIP_ZERO, SKIP_BCLR, SKIP_BSET} skip_t;

    // Decoded control word for one instruction.
    typedef struct packed {
        logic       w_dest;
        logic       f_dest;
        logic [3:0] alu_op;
        logic       b_sel;
        flow_t      flow;
        skip_t      skip;
        logic       illegal;
        logic       sleep;
    } ctrl_t;

    // Opcode match masks and values: (ir & mask) == value.
    localparam logic [11:0] OPM_EXACT  = 12'hFFF;
    localparam logic [11:0] OPM_TRIS   = 12'hFFE;
    localparam logic [11:0] OPM_FILE   = 12'hFE0;
    localparam logic [11:0] OPM_NIB    = 12'hF00;
    localparam logic [11:0] OPM_GOTO   = 12'hE00;

    localparam logic [11:0] OPV_NOP    = 12'h000;
    localparam logic [11:0] OPV_OPTION = 12'h002;
    localparam logic [11:0] OPV_SLEEP  = 12'h003;
    localparam logic [11:0] OPV_CLRWDT = 12'h004;
    localparam logic [11:0] OPV_TRIS   = 12'h006;
    localparam logic [11:0] OPV_MOVWF  = 12'h020;
    localparam logic [11:0] OPV_CLRW   = 12'h040;
    localparam logic [11:0] OPV_CLRF   = 12'h060;
    localparam logic [11:0] OPV_BCF    = 12'h400;
    localparam logic [11:0] OPV_BSF    = 12'h500;
    localparam logic [11:0] OPV_BTFSC  = 12'h600;
    localparam logic [11:0] OPV_BTFSS  = 12'h700;
    localparam logic [11:0] OPV_RETLW  = 12'h800;
    localparam logic [11:0] OPV_CALL   = 12'h900;
    localparam logic [11:0] OPV_GOTO   = 12'hA00;
    localparam logic [11:0] OPV_MOVLW  = 12'hC00;
    localparam logic [11:0] OPV_IORLW  = 12'hD00;
    localparam logic [11:0] OPV_ANDLW  = 12'hE00;
    localparam logic [11:0] OPV_XORLW  = 12'hF00;

    function automatic logic op_match(input logic [11:0] ir, input logic [11:0] mask,
                                      input logic [11:0] value);
        return (ir & mask) == value;
    endfunction

endpackage

// File: rtl/pic10_decoder.sv
// Combinational IR -> control word decoder for the PIC10 baseline ISA.
// Zero cycles: pure logic, valid whenever the IR is stable.
// No flow control. SLEEP decodes only when PIC10_CTRL_SLEEP_EN is defined.
module pic10_decoder
    import pic10_pkg::*;
(
    input  logic [11:0] ir,
    output ctrl_t       ctrl
);

    // Classify the instruction and build its control word; anything unmatched is illegal.
    always_comb begin
        ctrl = '0;
        if (ir[11:10] == 2'b00 && ir[9:7] != 3'b000) begin
            // Byte-oriented file ops (SUBWF..INCFSZ): d bit picks W or file.
            ctrl.alu_op = ir[9:6];
            ctrl.w_dest = ~ir[5];
            ctrl.f_dest = ir[5];
            if (ir[9:6] == ALU_DECSZ || ir[9:6] == ALU_INCSZ) begin
                ctrl.skip = SKIP_ZERO;
            end
        end else if (op_match(ir, OPM_FILE, OPV_MOVWF)) begin
            ctrl.f_dest = 1'b1;
            ctrl.alu_op = ALU_PASS_W;
        end else if (op_match(ir, OPM_FILE, OPV_CLRW)) begin
            ctrl.w_dest = 1'b1;
            ctrl.alu_op = ALU_ZERO;
        end else if (op_match(ir, OPM_FILE, OPV_CLRF)) begin
            ctrl.f_dest = 1'b1;
            ctrl.alu_op = ALU_ZERO;
        end else if (op_match(ir, OPM_EXACT, OPV_SLEEP)) begin
`ifdef PIC10_CTRL_SLEEP_EN
            ctrl.sleep = 1'b1;
`endif
        end else if (op_match(ir, OPM_EXACT, OPV_NOP) || op_match(ir, OPM_EXACT, OPV_OPTION) ||
                     op_match(ir, OPM_EXACT, OPV_CLRWDT) || op_match(ir, OPM_TRIS, OPV_TRIS)) begin
            // No architectural writes from this controller.
        end else if (op_match(ir, OPM_NIB, OPV_BCF)) begin
            ctrl.f_dest = 1'b1;
            ctrl.alu_op = ALU_AND;
        end else if (op_match(ir, OPM_NIB, OPV_BSF)) begin
            ctrl.f_dest = 1'b1;
            ctrl.alu_op = ALU_IOR;
        end else if (op_match(ir, OPM_NIB, OPV_BTFSC)) begin
            ctrl.skip = SKIP_BCLR;
        end else if (op_match(ir, OPM_NIB, OPV_BTFSS)) begin
            ctrl.skip = SKIP_BSET;
        end else if (op_match(ir, OPM_NIB, OPV_RETLW)) begin
            ctrl.w_dest = 1'b1;
            ctrl.b_sel  = 1'b1;
            ctrl.alu_op = ALU_MOV;
            ctrl.flow   = FLOW_RETLW;
        end else if (op_match(ir, OPM_NIB, OPV_CALL)) begin
            ctrl.flow = FLOW_CALL;
        end else if (op_match(ir, OPM_GOTO, OPV_GOTO)) begin
            ctrl.flow = FLOW_GOTO;
        end else if (op_match(ir, OPM_NIB, OPV_MOVLW)) begin
            ctrl.w_dest = 1'b1;
            ctrl.b_sel  = 1'b1;
            ctrl.alu_op = ALU_MOV;
        end else if (op_match(ir, OPM_NIB, OPV_IORLW)) begin
            ctrl.w_dest = 1'b1;
            ctrl.b_sel  = 1'b1;
            ctrl.alu_op = ALU_IOR;
        end else if (op_match(ir, OPM_NIB, OPV_ANDLW)) begin
            ctrl.w_dest = 1'b1;
            ctrl.b_sel  = 1'b1;
            ctrl.alu_op = ALU_AND;
        end else if (op_match(ir, OPM_NIB, OPV_XORLW)) begin
            ctrl.w_dest = 1'b1;
            ctrl.b_sel  = 1'b1;
            ctrl.alu_op = ALU_XOR;
        end else begin
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pic10_controller.sv
// PIC10 control unit: fixed fetch/decode/exec/writeback sequencer driving datapath strobes.
// Four cycles per instruction, strobes are combinational from the registered state.
// No backpressure; optional SLEEP halt enabled by PIC10_CTRL_SLEEP_EN.
module pic10_controller
    import pic10_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] ir_reg_bus,
    input  logic        alu_zero,
    input  logic        bit_val,
    input  logic        wake,
    output logic        load_ir_reg,
    output logic        inc_pc,
    output logic        load_pc,
    output logic [1:0]  pc_src_sel,
    output logic        stack_push,
    output logic        stack_pop,
    output logic        load_w_reg,
    output logic        load_f_reg,
    output logic [3:0]  alu_op,
    output logic        alu_b_sel,
    output logic [1:0]  phase,
    output logic        illegal,
    output logic        sleeping
);

    localparam logic [1:0] HOLD_INIT = 2'(RESET_HOLD);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] hold_cnt;
    logic       skip_q;
    logic       skip_eval;
    ctrl_t      ctrl;

    pic10_decoder u_decoder (
        .ir   (ir_reg_bus),
        .ctrl (ctrl)
    );

`ifndef PIC10_CTRL_SLEEP_EN
    // Without the sleep feature wake and the decoded sleep flag have no consumer.
    logic unused_sleep_inputs;
    assign unused_sleep_inputs = wake ^ ctrl.sleep;
`endif

    // Skip condition from the ALU/bit flags, meaningful only while in S_EXEC.
    always_comb begin
        case (ctrl.skip)
            SKIP_ZERO: skip_eval = alu_zero;
            SKIP_BCLR: skip_eval = ~bit_val;
            SKIP_BSET: skip_eval = bit_val;
            default:   skip_eval = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Post-reset hold counter: counts down to zero and stays there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= HOLD_INIT;
        end else if (hold_cnt != 2'd0) begin
            hold_cnt <= hold_cnt - 2'd1;
        end
    end

    // Capture the skip decision at the end of S_EXEC for use in S_WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= 1'b0;
        end else if (state == S_EXEC) begin
            skip_q <= skip_eval;
        end
    end

    // Next-state and per-state strobe generation; reset forces every output low.
    always_comb begin
        state_nxt   = state;
        load_ir_reg = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        pc_src_sel  = PC_SRC_GOTO;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
        load_w_reg  = 1'b0;
        load_f_reg  = 1'b0;
        alu_op      = 4'd0;
        alu_b_sel   = 1'b0;
        illegal     = 1'b0;
        sleeping    = 1'b0;
        phase       = 2'(state);
        case (state)
            S_FETCH: begin
                if (hold_cnt == 2'd0) begin
                    load_ir_reg = 1'b1;
                    inc_pc      = 1'b1;
                    state_nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_op    = ctrl.alu_op;
                alu_b_sel = ctrl.b_sel;
                illegal   = ctrl.illegal;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                alu_op    = ctrl.alu_op;
                alu_b_sel = ctrl.b_sel;
                state_nxt = S_WB;
            end
            S_WB: begin
                alu_op     = ctrl.alu_op;
                alu_b_sel  = ctrl.b_sel;
                load_w_reg = ctrl.w_dest;
                load_f_reg = ctrl.f_dest;
                case (ctrl.flow)
                    FLOW_GOTO: begin
                        load_pc    = 1'b1;
                        pc_src_sel = PC_SRC_GOTO;
                    end
                    FLOW_CALL: begin
                        load_pc    = 1'b1;
                        stack_push = 1'b1;
                        pc_src_sel = PC_SRC_CALL;
                    end
                    FLOW_RETLW: begin
                        load_pc    = 1'b1;
                        stack_pop  = 1'b1;
                        pc_src_sel = PC_SRC_STACK;
                    end
                    default: ;
                endcase
                // A taken skip steps over the next word; a PC load always wins.
                inc_pc    = skip_q & ~load_pc;
                state_nxt = S_FETCH;
`ifdef PIC10_CTRL_SLEEP_EN
                if (ctrl.sleep) begin
                    state_nxt = S_SLEEP;
                end
`endif
            end
`ifdef PIC10_CTRL_SLEEP_EN
            S_SLEEP: begin
                sleeping = 1'b1;
                if (wake) begin
                    state_nxt = S_FETCH;
                end
            end
`endif
            default: state_nxt = S_FETCH;
        endcase
        if (reset) begin
            load_ir_reg = 1'b0;
            inc_pc      = 1'b0;
            load_pc     = 1'b0;
            pc_src_sel  = 2'd0;
            stack_push  = 1'b0;
            stack_pop   = 1'b0;
            load_w_reg  = 1'b0;
            load_f_reg  = 1'b0;
            alu_op      = 4'd0;
            alu_b_sel   = 1'b0;
            illegal     = 1'b0;
            sleeping    = 1'b0;
            phase       = 2'd0;
        end
    end

endmodule
